// File: rtl/edge_capture_pkg.sv
// ----------------------------------------------------------------------------
// edge_capture_pkg : shared state encoding and default sizing for the capture path
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package edge_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } cap_state_e;

  localparam int         DEF_IMG_W      = 512;
  localparam int         DEF_IMG_H      = 512;
  localparam int         DEF_WORD_W     = 32;
  localparam int         DEF_FIFO_DEPTH = 16;
  localparam logic [7:0] DEF_THRESH     = 8'd128;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : single-clock show-ahead FIFO; push while full succeeds only with a pop
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import edge_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/edge_frame_capture.sv
// ----------------------------------------------------------------------------
// edge_frame_capture : thresholds edge pixels, packs them LSB-first into words
// and streams them out through a FIFO with frame-end marking and error flags.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module edge_frame_capture
  import edge_capture_pkg::*;
#(
  parameter int         IMG_W      = DEF_IMG_W,
  parameter int         IMG_H      = DEF_IMG_H,
  parameter int         WORD_W     = DEF_WORD_W,
  parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [7:0] THRESH     = DEF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_in_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_out_last,
  output logic              word_out_valid,
  input  logic              word_out_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              protocol_err
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic              done_q, done_d;
  logic              lastdrop_q, lastdrop_d;

  logic [WORD_W-1:0] word_asm;
  logic              pix_bit;
  logic              accept;
  logic              word_end;
  logic              frame_end;
  logic              pop;
  logic              drop;
  logic              last_pop;
  logic [WORD_W:0]   fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign pix_bit   = (pixel_in >= THRESH);
  assign accept    = pixel_in_valid && (state_q != DRAIN);
  assign word_end  = accept && (bit_q == BIT_LAST);
  assign frame_end = accept && (x_q == X_LAST) && (y_q == Y_LAST);
  assign pop       = word_out_ready && !fifo_empty;
  assign drop      = word_end && fifo_full && !pop;
  assign last_pop  = pop && fifo_rd[WORD_W];

  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (word_end),
    .push_data_i ({frame_end, word_asm}),
    .pop_i       (pop),
    .rd_data_o   (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    bit_d      = bit_q;
    pack_d     = pack_q;
    ovf_d      = ovf_q;
    perr_d     = perr_q;
    lastdrop_d = lastdrop_q;
    done_d     = 1'b0;

    word_asm          = pack_q;
    word_asm[bit_q]   = pix_bit;

    if (accept) begin
      if (word_end) begin
        pack_d = '0;
        bit_d  = '0;
      end else begin
        pack_d = word_asm;
        bit_d  = bit_q + 1'b1;
      end
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // A dropped last word means no popped entry will carry the flag,
    // so the drain must instead end when the FIFO runs dry.
    if (drop) begin
      ovf_d = 1'b1;
      if (frame_end) lastdrop_d = 1'b1;
    end

    case (state_q)
      IDLE:   if (accept) state_d = frame_end ? DRAIN : ACTIVE;
      ACTIVE: if (frame_end) state_d = DRAIN;
      DRAIN: begin
        if (pixel_in_valid) perr_d = 1'b1;
        if (last_pop ||
            (lastdrop_q && (fifo_empty || (pop && fifo_cnt == CW'(1))))) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          lastdrop_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      bit_q      <= '0;
      pack_q     <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      done_q     <= 1'b0;
      lastdrop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      bit_q      <= bit_d;
      pack_q     <= pack_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      done_q     <= done_d;
      lastdrop_q <= lastdrop_d;
    end
  end

  assign word_out_valid = !fifo_empty;
  assign word_out       = fifo_empty ? '0 : fifo_rd[WORD_W-1:0];
  assign word_out_last  = !fifo_empty && fifo_rd[WORD_W];
  assign frame_done     = done_q;
  assign overflow       = ovf_q;
  assign protocol_err   = perr_q;

endmodule

`default_nettype wire
